// File: rtl/transformer_seq_feeder.sv
// Streaming packer/unpacker around transformer_encoder_block: fills a SEQ x EMB frame, kicks the encoder, drains the result.
// Optional watchdog on the encoder wait is compiled in with `define SEQ_FEEDER_TIMEOUT_EN.
module transformer_seq_feeder #(
    parameter int SEQ     = 4,
    parameter int EMB     = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_W-1:0]                    s_data,
    input  logic                                 s_last,
    output logic [SEQ-1:0][EMB-1:0][DATA_W-1:0]  enc_seq,
    output logic                                 enc_start,
    input  logic                                 enc_done,
    input  logic [SEQ-1:0][EMB-1:0][DATA_W-1:0]  res_seq,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [DATA_W-1:0]                    m_data,
    output logic                                 m_last,
    output logic [15:0]                          frame_cnt,
    output logic                                 timeout
);

    localparam int N     = SEQ * EMB;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_PAD,
        ST_KICK,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N-1:0][DATA_W-1:0]  seq_q, seq_d;
    logic [N-1:0][DATA_W-1:0]  obuf_q, obuf_d;
    logic [N-1:0][DATA_W-1:0]  res_flat;
    logic [15:0]               frame_cnt_q, frame_cnt_d;
    logic                      armed_q;

    // Row-major packed [SEQ][EMB] has the same bit layout as a flat [N] element vector.
    assign res_flat = res_seq;
    assign enc_seq  = seq_q;

    assign s_ready   = (state_q == ST_LOAD) && armed_q;
    assign enc_start = (state_q == ST_KICK);
    assign m_valid   = (state_q == ST_DRAIN);
    assign m_data    = m_valid ? obuf_q[idx_q] : '0;
    assign m_last    = m_valid && (idx_q == LAST_IDX);
    assign frame_cnt = frame_cnt_q;

`ifdef SEQ_FEEDER_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT - 1);

    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = |32'(TIMEOUT);
    assign timeout            = 1'b0;
`endif

    // armed_q holds s_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            seq_q       <= '0;
            obuf_q      <= '0;
            frame_cnt_q <= '0;
            armed_q     <= 1'b0;
`ifdef SEQ_FEEDER_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            obuf_q      <= obuf_d;
            frame_cnt_q <= frame_cnt_d;
            armed_q     <= 1'b1;
`ifdef SEQ_FEEDER_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        obuf_d      = obuf_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SEQ_FEEDER_TIMEOUT_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    seq_d[idx_q] = s_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_KICK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (s_last) begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                seq_d[idx_q] = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_KICK;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_KICK: begin
`ifdef SEQ_FEEDER_TIMEOUT_EN
                wd_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving in the last watchdog cycle still completes the frame.
                if (enc_done) begin
                    obuf_d  = res_flat;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end
`ifdef SEQ_FEEDER_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_LOAD;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = ST_LOAD;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_transformer_seq_feeder.sv
// Directed self-checking bench for transformer_seq_feeder (SEQ=4, EMB=8, DATA_W=16, TIMEOUT=64).
module tb_transformer_seq_feeder;

    logic                       clk;
    logic                       rst;
    logic                       s_valid;
    logic                       s_ready;
    logic [15:0]                s_data;
    logic                       s_last;
    logic [3:0][7:0][15:0]      enc_seq;
    logic                       enc_start;
    logic                       enc_done;
    logic [3:0][7:0][15:0]      res_seq;
    logic                       m_valid;
    logic                       m_ready;
    logic [15:0]                m_data;
    logic                       m_last;
    logic [15:0]                frame_cnt;
    logic                       timeout;

    int assertCount;
    int failCount;
    int startCount;

    logic                  modelEn;
    logic [15:0]           modelMask;
    logic                  modelDone;
    logic [3:0][7:0][15:0] modelRes;
    logic                  manualDone;
    logic [3:0][7:0][15:0] manualRes;

    logic [15:0] frameVals [32];
    logic [15:0] expVals [32];

    assign enc_done = modelDone | manualDone;
    assign res_seq  = modelDone ? modelRes : manualRes;

    transformer_seq_feeder #(
        .SEQ(4), .EMB(8), .DATA_W(16), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .enc_seq(enc_seq), .enc_start(enc_start), .enc_done(enc_done), .res_seq(res_seq),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .frame_cnt(frame_cnt), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder model: returns enc_seq (optionally XOR-masked) a few cycles after each start pulse.
    initial begin
        modelDone = 1'b0;
        modelRes  = '0;
        forever begin
            @(posedge clk);
            if (enc_start && modelEn && !rst) begin
                modelRes = enc_seq ^ {32{modelMask}};
                repeat (4) @(negedge clk);
                modelDone = 1'b1;
                @(negedge clk);
                modelDone = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (enc_start) startCount++;
    end

    task automatic send_frame(input int n, input logic lastFlag);
        for (int i = 0; i < n; i++) begin
            int guard;
            s_valid = 1'b1;
            s_data  = frameVals[i];
            s_last  = (i == n - 1) && lastFlag;
            guard   = 0;
            while (!s_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            assertCount++;
            if (s_ready !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL send_ready: s_ready=%b required 1 at element %0d", s_ready, i);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_m_valid(input string tag);
        int guard;
        guard = 0;
        while (!m_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        assertCount++;
        if (m_valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s_mvalid_wait: m_valid=%b required 1 within 60 cycles", tag, m_valid);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        assertCount++;
        if ({s_ready, enc_start, m_valid, m_last, timeout} !== 5'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got %b required 00000", {s_ready, enc_start, m_valid, m_last, timeout});
        end
        assertCount++;
        if (enc_seq !== '0 || m_data !== 16'd0 || frame_cnt !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL reset_data: m_data=%0h frame_cnt=%0d enc_seq nonzero=%b", m_data, frame_cnt, |enc_seq);
        end
        rst = 1'b0;
        assertCount++;
        if (s_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_release_ready: s_ready=%b required 0 before first edge", s_ready);
        end
        @(negedge clk);
        assertCount++;
        if (s_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_ready_rise: s_ready=%b required 1", s_ready);
        end
    endtask

    task automatic test_full_frame();
        int s0;
        $display("[TB] test_full_frame");
        modelEn   = 1'b1;
        modelMask = 16'h0000;
        s0 = startCount;
        for (int i = 0; i < 32; i++) frameVals[i] = 16'(i + 1);
        send_frame(32, 1'b0);
        assertCount++;
        if (enc_start !== 1'b1 || s_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_kick: enc_start=%b s_ready=%b required 1/0", enc_start, s_ready);
        end
        @(negedge clk);
        assertCount++;
        if (enc_start !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_kick_width: enc_start=%b required 0", enc_start);
        end
        wait_m_valid("full");
        for (int j = 0; j < 32; j++) begin
            assertCount++;
            if (m_valid !== 1'b1 || m_data !== 16'(j + 1) || m_last !== (j == 31)) begin
                failCount++;
                $display("[TB] FAIL full_drain[%0d]: valid=%b data=%0d last=%b required 1/%0d/%b",
                         j, m_valid, m_data, m_last, j + 1, j == 31);
            end
            @(negedge clk);
        end
        assertCount++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 16'd1) begin
            failCount++;
            $display("[TB] FAIL full_end: m_valid=%b s_ready=%b frame_cnt=%0d required 0/1/1", m_valid, s_ready, frame_cnt);
        end
        assertCount++;
        if (startCount - s0 !== 1) begin
            failCount++;
            $display("[TB] FAIL full_start_count: got %0d pulses required 1", startCount - s0);
        end
    endtask

    task automatic test_short_frame();
        logic [3:0][7:0][15:0] expSeq;
        int cyc;
        int padBad;
        $display("[TB] test_short_frame");
        modelEn      = 1'b1;
        modelMask    = 16'h0000;
        frameVals[0] = 16'd10;
        frameVals[1] = 16'd20;
        frameVals[2] = 16'd30;
        send_frame(3, 1'b1);
        cyc    = 1;
        padBad = 0;
        while (!enc_start && cyc < 40) begin
            if (s_ready !== 1'b0) padBad++;
            @(negedge clk);
            cyc++;
        end
        assertCount++;
        if (cyc !== 30) begin
            failCount++;
            $display("[TB] FAIL short_kick_delay: enc_start after %0d cycles required 30", cyc);
        end
        assertCount++;
        if (padBad !== 0) begin
            failCount++;
            $display("[TB] FAIL short_pad_ready: s_ready high in %0d PAD cycles required 0", padBad);
        end
        expSeq       = '0;
        expSeq[0][0] = 16'd10;
        expSeq[0][1] = 16'd20;
        expSeq[0][2] = 16'd30;
        assertCount++;
        if (enc_seq !== expSeq) begin
            failCount++;
            $display("[TB] FAIL short_enc_seq: got %h required %h", enc_seq, expSeq);
        end
        wait_m_valid("short");
        for (int j = 0; j < 32; j++) begin
            logic [15:0] e;
            e = (j < 3) ? 16'(10 * (j + 1)) : 16'd0;
            assertCount++;
            if (m_valid !== 1'b1 || m_data !== e) begin
                failCount++;
                $display("[TB] FAIL short_drain[%0d]: valid=%b data=%0d required 1/%0d", j, m_valid, m_data, e);
            end
            @(negedge clk);
        end
        assertCount++;
        if (frame_cnt !== 16'd2) begin
            failCount++;
            $display("[TB] FAIL short_frame_cnt: got %0d required 2", frame_cnt);
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [15:0] lfsr;
        logic        rdy;
        logic        acc;
        int          j;
        int          cyc;
        $display("[TB] test_back_to_back_stall");
        modelEn   = 1'b1;
        modelMask = 16'h5A5A;
        for (int i = 0; i < 32; i++) begin
            frameVals[i] = 16'(16'h0100 + 3 * i);
            expVals[i]   = frameVals[i] ^ 16'h5A5A;
        end
        send_frame(32, 1'b1);
        wait_m_valid("stall");
        lfsr = 16'hACE1;
        j    = 0;
        cyc  = 0;
        while (j < 32 && cyc < 400) begin
            assertCount++;
            if (m_valid !== 1'b1 || m_data !== expVals[j] || m_last !== (j == 31)) begin
                failCount++;
                $display("[TB] FAIL stall_drain[%0d]: valid=%b data=%0h last=%b required 1/%0h/%b",
                         j, m_valid, m_data, m_last, expVals[j], j == 31);
            end
            rdy     = lfsr[0];
            m_ready = rdy;
            lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            acc     = rdy && m_valid;
            @(negedge clk);
            if (acc) j++;
            cyc++;
        end
        m_ready = 1'b1;
        assertCount++;
        if (j !== 32 || m_valid !== 1'b0 || frame_cnt !== 16'd3) begin
            failCount++;
            $display("[TB] FAIL stall_end: drained=%0d m_valid=%b frame_cnt=%0d required 32/0/3", j, m_valid, frame_cnt);
        end
    endtask

    task automatic test_ignore_done();
        $display("[TB] test_ignore_done");
        modelEn    = 1'b0;
        manualRes  = {32{16'h7777}};
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
        assertCount++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || enc_start !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ignore_load_done: m_valid=%b s_ready=%b enc_start=%b required 0/1/0", m_valid, s_ready, enc_start);
        end
        for (int i = 0; i < 32; i++) begin
            frameVals[i] = 16'(200 + i);
            expVals[i]   = frameVals[i] ^ 16'h00FF;
        end
        send_frame(32, 1'b0);
        assertCount++;
        if (enc_start !== 1'b1 || s_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ignore_kick: enc_start=%b s_ready=%b required 1/0", enc_start, s_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            assertCount++;
            if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL ignore_wait[%0d]: s_ready=%b m_valid=%b required 0/0", k, s_ready, m_valid);
            end
        end
        for (int i = 0; i < 32; i++) manualRes[i / 8][i % 8] = expVals[i];
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
        m_ready    = 1'b0;
        assertCount++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== expVals[0]) begin
            failCount++;
            $display("[TB] FAIL ignore_drain_start: m_valid=%b s_ready=%b data=%0h required 1/0/%0h", m_valid, s_ready, m_data, expVals[0]);
        end
        manualRes  = {32{16'h7777}};
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
        @(negedge clk);
        assertCount++;
        if (m_data !== expVals[0] || m_last !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ignore_drain_done: data=%0h last=%b required %0h/0", m_data, m_last, expVals[0]);
        end
        m_ready = 1'b1;
        for (int j = 0; j < 32; j++) begin
            assertCount++;
            if (m_valid !== 1'b1 || m_data !== expVals[j]) begin
                failCount++;
                $display("[TB] FAIL ignore_drain[%0d]: valid=%b data=%0h required 1/%0h", j, m_valid, m_data, expVals[j]);
            end
            @(negedge clk);
        end
        assertCount++;
        if (frame_cnt !== 16'd4 || s_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ignore_end: frame_cnt=%0d s_ready=%b required 4/1", frame_cnt, s_ready);
        end
    endtask

    task automatic test_timeout();
        $display("[TB] test_timeout");
        modelEn = 1'b0;
        for (int i = 0; i < 32; i++) frameVals[i] = 16'(16'h8000 + i);
`ifdef SEQ_FEEDER_TIMEOUT_EN
        send_frame(32, 1'b0);
        repeat (64) @(negedge clk);
        assertCount++;
        if (timeout !== 1'b0 || s_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_early: timeout=%b s_ready=%b required 0/0 in WAIT cycle 64", timeout, s_ready);
        end
        @(negedge clk);
        assertCount++;
        if (timeout !== 1'b1 || s_ready !== 1'b1 || frame_cnt !== 16'd4 || m_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_fire: timeout=%b s_ready=%b frame_cnt=%0d m_valid=%b required 1/1/4/0",
                     timeout, s_ready, frame_cnt, m_valid);
        end
        send_frame(32, 1'b0);
        repeat (64) @(negedge clk);
        for (int i = 0; i < 32; i++) manualRes[i / 8][i % 8] = frameVals[i];
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
        assertCount++;
        if (m_valid !== 1'b1 || m_data !== frameVals[0]) begin
            failCount++;
            $display("[TB] FAIL timeout_last_done: m_valid=%b data=%0h required 1/%0h", m_valid, m_data, frameVals[0]);
        end
        repeat (32) @(negedge clk);
        assertCount++;
        if (frame_cnt !== 16'd5 || timeout !== 1'b1 || s_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL timeout_recover: frame_cnt=%0d timeout=%b s_ready=%b required 5/1/1", frame_cnt, timeout, s_ready);
        end
`else
        send_frame(32, 1'b0);
        repeat (100) @(negedge clk);
        assertCount++;
        if (timeout !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL no_watchdog: timeout=%b s_ready=%b m_valid=%b required 0/0/0", timeout, s_ready, m_valid);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int  s0;
        logic sawValid;
        $display("[TB] test_reset_mid");
        if (s_ready !== 1'b1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
        modelEn = 1'b0;
        for (int i = 0; i < 32; i++) frameVals[i] = 16'(16'h4000 + i);
        send_frame(32, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        assertCount++;
        if ({s_ready, enc_start, m_valid, timeout} !== 4'b0 || enc_seq !== '0 || frame_cnt !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL reset_wait: flags=%b frame_cnt=%0d enc_seq nonzero=%b required 0000/0/0",
                     {s_ready, enc_start, m_valid, timeout}, frame_cnt, |enc_seq);
        end
        @(negedge clk);
        rst = 1'b0;
        s0  = startCount;
        @(negedge clk);
        assertCount++;
        if (s_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_wait_ready: s_ready=%b required 1", s_ready);
        end
        repeat (10) @(negedge clk);
        assertCount++;
        if (startCount !== s0 || m_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_wait_quiet: extra starts=%0d m_valid=%b required 0/0", startCount - s0, m_valid);
        end
        modelEn   = 1'b1;
        modelMask = 16'h0000;
        send_frame(32, 1'b0);
        wait_m_valid("rstdrain");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        assertCount++;
        if (m_valid !== 1'b0 || m_data !== 16'd0 || m_last !== 1'b0 || enc_seq !== '0 || frame_cnt !== 16'd0) begin
            failCount++;
            $display("[TB] FAIL reset_drain: m_valid=%b m_data=%0h m_last=%b frame_cnt=%0d required 0/0/0/0",
                     m_valid, m_data, m_last, frame_cnt);
        end
        @(negedge clk);
        rst      = 1'b0;
        s0       = startCount;
        sawValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_valid) sawValid = 1'b1;
        end
        assertCount++;
        if (sawValid !== 1'b0 || startCount !== s0 || s_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_drain_quiet: m_valid seen=%b extra starts=%0d s_ready=%b required 0/0/1",
                     sawValid, startCount - s0, s_ready);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        startCount  = 0;
        rst         = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        m_ready     = 1'b1;
        modelEn     = 1'b0;
        modelMask   = '0;
        manualDone  = 1'b0;
        manualRes   = '0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_short_frame();
        test_back_to_back_stall();
        test_ignore_done();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
